gshare_btb_ras_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_ras.sv | 69 ++++++
 rtl/gshare_btb_ras_predictor.sv | 177 +++++++++++++++++
 tb/tb_gshare_btb_ras_predictor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/BTB/RAS branch predictor.
// Holds the branch-kind encoding, the PHT reset value and the
// 2-bit saturating-counter next-value helper.
package bp_pkg;

    typedef enum logic [1:0] {
        KIND_COND = 2'b00,
        KIND_JUMP = 2'b01,
        KIND_CALL = 2'b10,
        KIND_RET  = 2'b11
    } bp_kind_e;

    // Weakly not-taken.
    localparam logic [1:0] PHT_RESET = 2'b01;

    // Next value of a 2-bit saturating counter, clamped to 0..3.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cnt == 2'b11) ? 2'b11 : (cnt + 2'b01);
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : (cnt - 2'b01);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Return address stack implemented as a circular buffer.
// Ports: clk, reset (sync, active-high), push/pop strobes, push_data,
// top (most recently pushed live entry), empty (no live entries).
// A push on a full stack overwrites the oldest entry; a pop on an
// empty stack is ignored.
module bp_ras
    import bp_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_BITS = $clog2(RAS_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [31:0]         mem_q [RAS_DEPTH];
    logic [31:0]         mem_d [RAS_DEPTH];
    logic [PTR_BITS-1:0] sp_q, sp_d;       // next slot to write
    logic [CNT_BITS-1:0] count_q, count_d; // live entries, saturates at depth
    logic [PTR_BITS-1:0] top_ptr_s;

    assign top_ptr_s = sp_q - {{(PTR_BITS-1){1'b0}}, 1'b1};
    assign top       = mem_q[top_ptr_s];
    assign empty     = (count_q == {CNT_BITS{1'b0}});

    // Next-state for pointer, count and storage.
    always_comb begin
        mem_d   = mem_q;
        sp_d    = sp_q;
        count_d = count_q;
        if (push) begin
            mem_d[sp_q] = push_data;
            sp_d        = sp_q + {{(PTR_BITS-1){1'b0}}, 1'b1};
            if (count_q != CNT_BITS'(RAS_DEPTH)) begin
                count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else if (pop && !empty) begin
            sp_d    = top_ptr_s;
            count_d = count_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            sp_d    = sp_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            sp_q    <= {PTR_BITS{1'b0}};
            count_q <= {CNT_BITS{1'b0}};
        end else begin
            mem_q   <= mem_d;
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gshare_btb_ras_predictor.sv
// IF-stage branch predictor: tagged BTB + 2-bit PHT (gshare or bimodal
// index) + return address stack + performance counters.
// Ports: clk, reset (sync, active-high); pc_addr (IF lookup PC);
// valid/taken/ex_addr/target_addr/ex_kind/mispredict (EX resolution);
// hit/prediction/predicted_target (combinational lookup result);
// ghr (global history), branch_count, mispredict_count.
// Lookups see pre-update state; all updates happen on the clock edge.
module gshare_btb_ras_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int HIST_BITS  = 5,
    parameter int RAS_DEPTH  = 4,
    parameter int GSHARE     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_addr,
    input  logic                 valid,
    input  logic                 taken,
    input  logic [31:0]          ex_addr,
    input  logic [31:0]          target_addr,
    input  logic [1:0]           ex_kind,
    input  logic                 mispredict,
    output logic                 hit,
    output logic                 prediction,
    output logic [31:0]          predicted_target,
    output logic [HIST_BITS-1:0] ghr,
    output logic [31:0]          branch_count,
    output logic [31:0]          mispredict_count
);

    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]    btb_valid_q, btb_valid_d;
    logic [TAG_BITS-1:0]   btb_tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag_d    [ENTRIES];
    logic [31:0]           btb_target_q [ENTRIES];
    logic [31:0]           btb_target_d [ENTRIES];
    bp_kind_e              btb_kind_q   [ENTRIES];
    bp_kind_e              btb_kind_d   [ENTRIES];
    logic [1:0]            pht_q        [ENTRIES];
    logic [1:0]            pht_d        [ENTRIES];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [31:0]           branch_count_q, branch_count_d;
    logic [31:0]           mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] if_idx_s, if_pidx_s, ex_idx_s, ex_pidx_s, hist_ext_s;
    logic [TAG_BITS-1:0]   if_tag_s, ex_tag_s;
    bp_kind_e              ex_kind_s;
    logic                  ras_push_s, ras_pop_s, ras_empty_s;
    logic [31:0]           ras_top_s;
    logic                  unused_s;

    // Low PC bits are always zero for aligned instructions.
    assign unused_s = ^{pc_addr[1:0], ex_addr[1:0]};

    assign if_idx_s   = pc_addr[INDEX_BITS+1:2];
    assign if_tag_s   = pc_addr[31:INDEX_BITS+2];
    assign ex_idx_s   = ex_addr[INDEX_BITS+1:2];
    assign ex_tag_s   = ex_addr[31:INDEX_BITS+2];
    assign ex_kind_s  = bp_kind_e'(ex_kind);
    assign hist_ext_s = INDEX_BITS'(ghr_q);
    assign if_pidx_s  = (GSHARE != 0) ? (if_idx_s ^ hist_ext_s) : if_idx_s;
    assign ex_pidx_s  = (GSHARE != 0) ? (ex_idx_s ^ hist_ext_s) : ex_idx_s;

    assign ras_push_s = valid && (ex_kind_s == KIND_CALL);
    assign ras_pop_s  = valid && (ex_kind_s == KIND_RET);

    bp_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (ex_addr + 32'd4),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );

    // Combinational lookup from the IF PC.
    always_comb begin
        hit              = btb_valid_q[if_idx_s] && (btb_tag_q[if_idx_s] == if_tag_s);
        prediction       = 1'b0;
        predicted_target = 32'd0;
        if (hit) begin
            case (btb_kind_q[if_idx_s])
                KIND_COND: begin
                    prediction       = pht_q[if_pidx_s][1];
                    predicted_target = prediction ? btb_target_q[if_idx_s] : 32'd0;
                end
                KIND_JUMP, KIND_CALL: begin
                    prediction       = 1'b1;
                    predicted_target = btb_target_q[if_idx_s];
                end
                KIND_RET: begin
                    prediction       = !ras_empty_s;
                    predicted_target = ras_empty_s ? 32'd0 : ras_top_s;
                end
                default: begin
                    prediction       = 1'b0;
                    predicted_target = 32'd0;
                end
            endcase
        end else begin
            prediction       = 1'b0;
            predicted_target = 32'd0;
        end
    end

    // Next-state for BTB, PHT, history and counters on an EX resolution.
    always_comb begin
        btb_valid_d        = btb_valid_q;
        btb_tag_d          = btb_tag_q;
        btb_target_d       = btb_target_q;
        btb_kind_d         = btb_kind_q;
        pht_d              = pht_q;
        ghr_d              = ghr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (valid) begin
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end else begin
                mispredict_count_d = mispredict_count_q;
            end
            if (taken) begin
                btb_valid_d[ex_idx_s]  = 1'b1;
                btb_tag_d[ex_idx_s]    = ex_tag_s;
                btb_target_d[ex_idx_s] = target_addr;
                btb_kind_d[ex_idx_s]   = ex_kind_s;
            end else begin
                btb_valid_d = btb_valid_q;
            end
            if (ex_kind_s == KIND_COND) begin
                pht_d[ex_pidx_s] = sat_next(pht_q[ex_pidx_s], taken);
                // Shift form stays legal when HIST_BITS is 1.
                ghr_d = (ghr_q << 1) | HIST_BITS'(taken);
            end else begin
                ghr_d = ghr_q;
            end
        end else begin
            branch_count_d = branch_count_q;
        end
    end

    // State registers with synchronous reset (reset beats a concurrent update).
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_q[i]    <= {TAG_BITS{1'b0}};
                btb_target_q[i] <= 32'd0;
                btb_kind_q[i]   <= KIND_COND;
                pht_q[i]        <= PHT_RESET;
            end
            ghr_q              <= {HIST_BITS{1'b0}};
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            btb_valid_q        <= btb_valid_d;
            btb_tag_q          <= btb_tag_d;
            btb_target_q       <= btb_target_d;
            btb_kind_q         <= btb_kind_d;
            pht_q              <= pht_d;
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign ghr              = ghr_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_gshare_btb_ras_predictor.sv
// Scoreboard bench: two predictor instances (bimodal and gshare) share
// all inputs. Lookup tasks push hand-computed expectations into a queue;
// an independent monitor pops and compares on the falling edge.
module tb_gshare_btb_ras_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_addr = 32'd0;
    logic        valid = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] target_addr = 32'd0;
    logic [1:0]  ex_kind = 2'b00;
    logic        mispredict = 1'b0;
    logic        chk = 1'b0;

    logic        hit0, pred0, hit1, pred1;
    logic [31:0] tgt0, tgt1, bc0, bc1, mc0, mc1;
    logic [4:0]  ghr0, ghr1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        int          sel;
        logic        hit;
        logic        pred;
        logic [31:0] tgt;
        logic [4:0]  ghr;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gshare_btb_ras_predictor #(.INDEX_BITS(5), .HIST_BITS(5), .RAS_DEPTH(4), .GSHARE(0)) u0 (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .valid(valid), .taken(taken),
        .ex_addr(ex_addr), .target_addr(target_addr), .ex_kind(ex_kind), .mispredict(mispredict),
        .hit(hit0), .prediction(pred0), .predicted_target(tgt0), .ghr(ghr0),
        .branch_count(bc0), .mispredict_count(mc0));

    gshare_btb_ras_predictor #(.INDEX_BITS(5), .HIST_BITS(5), .RAS_DEPTH(4), .GSHARE(1)) u1 (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .valid(valid), .taken(taken),
        .ex_addr(ex_addr), .target_addr(target_addr), .ex_kind(ex_kind), .mispredict(mispredict),
        .hit(hit1), .prediction(pred1), .predicted_target(tgt1), .ghr(ghr1),
        .branch_count(bc1), .mispredict_count(mc1));

    // Monitor: compare the selected instance against the next expectation.
    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: lookup presented with no expectation queued");
            end else begin
                exp_t e;
                logic        h, p;
                logic [31:0] t, b, m;
                logic [4:0]  g;
                e = sb.pop_front();
                if (e.sel == 0) begin
                    h = hit0; p = pred0; t = tgt0; g = ghr0; b = bc0; m = mc0;
                end else begin
                    h = hit1; p = pred1; t = tgt1; g = ghr1; b = bc1; m = mc1;
                end
                vectors++;
                if (h !== e.hit || p !== e.pred || t !== e.tgt || g !== e.ghr ||
                    b !== e.bc || m !== e.mc) begin
                    miscompares++;
                    $display("FAIL %s (u%0d): got hit=%b pred=%b tgt=%h ghr=%h bc=%0d mc=%0d, want hit=%b pred=%b tgt=%h ghr=%h bc=%0d mc=%0d",
                             e.name, e.sel, h, p, t, g, b, m,
                             e.hit, e.pred, e.tgt, e.ghr, e.bc, e.mc);
                end
            end
        end
    end

    task automatic lookup(input string name, input int sel, input logic [31:0] pc,
                          input logic h, input logic p, input logic [31:0] t,
                          input logic [4:0] g, input logic [31:0] b, input logic [31:0] m);
        exp_t e;
        e.name = name; e.sel = sel; e.hit = h; e.pred = p; e.tgt = t;
        e.ghr = g; e.bc = b; e.mc = m;
        pc_addr = pc;
        sb.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic [1:0] k,
                       input logic tk, input logic mp);
        ex_addr = a; target_addr = t; ex_kind = k; taken = tk; mispredict = mp;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        mispredict = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state.
        do_reset();
        lookup("reset_u0", 0, 32'h100, 1'b0, 1'b0, 32'h0, 5'd0, 32'd0, 32'd0);
        lookup("reset_u1", 1, 32'h100, 1'b0, 1'b0, 32'h0, 5'd0, 32'd0, 32'd0);

        // Bimodal training and saturation; gshare view of first step.
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0);
        lookup("bimodal_taken", 0, 32'h40, 1'b1, 1'b1, 32'h80, 5'd1, 32'd1, 32'd0);
        lookup("gshare_alias_first", 1, 32'h40, 1'b1, 1'b0, 32'h0, 5'd1, 32'd1, 32'd0);
        upd(32'h40, 32'h80, 2'b00, 1'b0, 1'b0);
        lookup("bimodal_not_taken", 0, 32'h40, 1'b1, 1'b0, 32'h0, 5'd2, 32'd2, 32'd0);
        for (int i = 0; i < 3; i++) upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0);
        upd(32'h40, 32'h80, 2'b00, 1'b0, 1'b0);
        lookup("bimodal_saturate", 0, 32'h40, 1'b1, 1'b1, 32'h80, 5'd14, 32'd6, 32'd0);

        // Gshare history-dependent indexing.
        do_reset();
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0);
        lookup("gshare_idx11", 1, 32'h40, 1'b1, 1'b0, 32'h0, 5'd1, 32'd1, 32'd0);
        upd(32'h40, 32'h80, 2'b00, 1'b1, 1'b0);
        lookup("gshare_idx13", 1, 32'h40, 1'b1, 1'b0, 32'h0, 5'd3, 32'd2, 32'd0);
        lookup("bimodal_same_seq", 0, 32'h40, 1'b1, 1'b1, 32'h80, 5'd3, 32'd2, 32'd0);

        // Calls, return via RAS, jump, tag-mismatch miss.
        do_reset();
        upd(32'h200, 32'h400, 2'b10, 1'b1, 1'b0);
        upd(32'h408, 32'h204, 2'b11, 1'b1, 1'b0);
        upd(32'h300, 32'h400, 2'b10, 1'b1, 1'b0);
        lookup("ras_ret", 1, 32'h408, 1'b1, 1'b1, 32'h304, 5'd0, 32'd3, 32'd0);
        upd(32'h500, 32'h600, 2'b01, 1'b1, 1'b0);
        lookup("jump", 0, 32'h500, 1'b1, 1'b1, 32'h600, 5'd0, 32'd4, 32'd0);
        lookup("tag_miss", 0, 32'h200, 1'b0, 1'b0, 32'h0, 5'd0, 32'd4, 32'd0);

        // RAS: pop on empty, overflow, then drain to empty.
        do_reset();
        upd(32'h3008, 32'h0, 2'b11, 1'b1, 1'b0);
        lookup("ras_empty_first", 0, 32'h3008, 1'b1, 1'b0, 32'h0, 5'd0, 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) upd(32'h1000 + 32'(i) * 32'h100, 32'h2000, 2'b10, 1'b1, 1'b0);
        lookup("ras_top0", 0, 32'h3008, 1'b1, 1'b1, 32'h1404, 5'd0, 32'd6, 32'd0);
        upd(32'h3008, 32'h1404, 2'b11, 1'b1, 1'b0);
        lookup("ras_top1", 0, 32'h3008, 1'b1, 1'b1, 32'h1304, 5'd0, 32'd7, 32'd0);
        upd(32'h3008, 32'h1304, 2'b11, 1'b1, 1'b0);
        lookup("ras_top2", 1, 32'h3008, 1'b1, 1'b1, 32'h1204, 5'd0, 32'd8, 32'd0);
        upd(32'h3008, 32'h1204, 2'b11, 1'b1, 1'b0);
        lookup("ras_top3", 0, 32'h3008, 1'b1, 1'b1, 32'h1104, 5'd0, 32'd9, 32'd0);
        upd(32'h3008, 32'h1104, 2'b11, 1'b1, 1'b0);
        lookup("ras_drained", 0, 32'h3008, 1'b1, 1'b0, 32'h0, 5'd0, 32'd10, 32'd0);

        // Counters, ignored mispredict without valid, then reset beats valid.
        do_reset();
        for (int i = 0; i < 10; i++) upd(32'h700, 32'h800, 2'b01, 1'b1, (i % 3 == 2));
        mispredict = 1'b1;
        lookup("counters", 0, 32'h700, 1'b1, 1'b1, 32'h800, 5'd0, 32'd10, 32'd3);
        mispredict = 1'b0;
        ex_addr = 32'h40; target_addr = 32'h80; ex_kind = 2'b00; taken = 1'b1;
        mispredict = 1'b1; valid = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0; reset = 1'b0; mispredict = 1'b0;
        lookup("reset_wins_u0", 0, 32'h700, 1'b0, 1'b0, 32'h0, 5'd0, 32'd0, 32'd0);
        lookup("reset_wins_u1", 1, 32'h40, 1'b0, 1'b0, 32'h0, 5'd0, 32'd0, 32'd0);

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
